// File: rtl/pit_multi_chan.sv
// pit_multi_chan: NCH-channel programmable interval timer behind a WISHBONE slave port
module pit_multi_chan #(
  parameter int NCH    = 4,
  parameter int CWIDTH = 16,
  parameter int AWIDTH = 5
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [AWIDTH-1:0] wb_adr_i,
  input  logic [15:0]       wb_dat_i,
  output logic [15:0]       wb_dat_o,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  input  logic [1:0]        wb_sel_i,
  output logic              wb_ack_o,
  input  logic              ext_sync_i,
  output logic [NCH-1:0]    pit_o,
  output logic [NCH-1:0]    cnt_flag_o,
  output logic              pit_irq_o
);
  localparam int CHW = AWIDTH - 2;
  logic [NCH-1:0] ena, irqen, flag, oneshot, cascade, tick, roll, pterm, sel_ch;
  logic [3:0] ps [NCH];
  logic [14:0] pre [NCH];
  logic [CWIDTH-1:0] modv [NCH], cnt [NCH];
  logic [15:0] mnew [NCH];
  logic [15:0] rdata, m16;
  logic [CHW-1:0] ch;
  logic [1:0] rs;
  logic acc, wr, hit, carry, t;
  assign cnt_flag_o = flag;
  assign pit_irq_o = |(flag & irqen);
  // carry walks up the channels so a cascaded channel sees the rollover of the one below in the same clock
  always_comb begin
    ch = wb_adr_i[AWIDTH-1:2];
    rs = wb_adr_i[1:0];
    hit = int'(ch) < NCH;
    acc = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    wr = acc & wb_we_i & hit;
    {sel_ch, pterm, roll, tick, pit_o} = '0;
    rdata = '0;
    m16 = '0;
    t = 1'b0;
    carry = ext_sync_i;
    for (int i = 0; i < NCH; i++) begin
      sel_ch[i] = wr && int'(ch) == i;
      pterm[i] = pre[i] == ~(15'h7fff << ps[i]);
      roll[i] = (modv[i] != '0) ? cnt[i] >= modv[i] : &cnt[i];
      t = ena[i] & (cascade[i] ? carry : pterm[i]);
      tick[i] = t;
      carry = wb_rst_ni & t & roll[i];
      pit_o[i] = carry;
      m16 = 16'(modv[i]);
      mnew[i] = {wb_sel_i[1] ? wb_dat_i[15:8] : m16[15:8], wb_sel_i[0] ? wb_dat_i[7:0] : m16[7:0]};
      if (hit && int'(ch) == i)
        rdata = rs == 2'd0 ? {4'b0, ps[i], 3'b0, cascade[i], oneshot[i], flag[i], irqen[i], ena[i]}
              : rs == 2'd1 ? m16 : rs == 2'd2 ? 16'(cnt[i]) : 16'(flag);
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      {ena, irqen, flag, oneshot, cascade} <= '0;
      for (int i = 0; i < NCH; i++) begin
        ps[i] <= '0;
        pre[i] <= '0;
        modv[i] <= '0;
        cnt[i] <= CWIDTH'(1);
      end
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= (acc && !wb_we_i) ? rdata : 16'h0;
      for (int i = 0; i < NCH; i++) begin
        if (sel_ch[i] && rs == 2'd0 && wb_sel_i[0]) begin
          irqen[i] <= wb_dat_i[1];
          oneshot[i] <= wb_dat_i[3];
          cascade[i] <= wb_dat_i[4];
        end
        if (sel_ch[i] && rs == 2'd0 && wb_sel_i[1]) ps[i] <= wb_dat_i[11:8];
        if (sel_ch[i] && rs == 2'd1) modv[i] <= mnew[i][CWIDTH-1:0];
        ena[i] <= (pit_o[i] & oneshot[i]) ? 1'b0 : (sel_ch[i] && rs == 2'd0 && wb_sel_i[0]) ? wb_dat_i[0] : ena[i];
        flag[i] <= pit_o[i] | (flag[i] & ~(wr & wb_sel_i[0] & ((sel_ch[i] & rs == 2'd0 & wb_dat_i[2]) | (rs == 2'd3 & wb_dat_i[i]))));
        pre[i] <= (ena[i] && !cascade[i] && !pterm[i]) ? pre[i] + 15'd1 : '0;
        cnt[i] <= !ena[i] ? CWIDTH'(1) : !tick[i] ? cnt[i] : roll[i] ? CWIDTH'(1) : cnt[i] + CWIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_pit_multi_chan.sv
// tb_pit_multi_chan: directed bench with a period/tick-count model of every channel
module tb_pit_multi_chan;
  localparam int NCH = 4;
  logic clk = 0, rst_n = 0, we = 0, stb = 0, cyc = 0, ext = 0, ack, irq;
  logic [4:0] adr = '0;
  logic [15:0] din = '0, dout;
  logic [1:0] sel = '0;
  logic [NCH-1:0] pit, flg, ep;
  logic [NCH-1:0] m_ena, m_irqen, m_flag, m_os, m_casc;
  int m_ps [NCH], m_mod [NCH], m_t0 [NCH], m_cin [NCH], m_lastp [NCH], m_osclr [NCH];
  int pcnt [NCH], dut_last [NCH];
  int cyc_n = 0, n_chk = 0, n_fail = 0, coin = 0, e0, t0, p0, p1, c0;
  logic sin;
  longint me;
  bit chk_on = 0;

  pit_multi_chan #(.NCH(NCH), .CWIDTH(16), .AWIDTH(5)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(din), .wb_dat_o(dout),
    .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_sel_i(sel), .wb_ack_o(ack),
    .ext_sync_i(ext), .pit_o(pit), .cnt_flag_o(flg), .pit_irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic mdl_reset();
    {m_ena, m_irqen, m_flag, m_os, m_casc} = '0;
    for (int n = 0; n < NCH; n++) begin
      m_ps[n] = 0; m_mod[n] = 0; m_t0[n] = 0; m_cin[n] = 0; m_lastp[n] = -10; m_osclr[n] = -10;
    end
  endtask

  // e is the clock edge on which the write commits; a rollover in cycle e-1 beats it
  task automatic mdl_write(input logic [4:0] a, input logic [15:0] d, input logic [1:0] s, input int e);
    int c;
    c = int'(a[4:2]);
    if (c >= NCH) return;
    case (a[1:0])
      2'd0: begin
        if (s[1]) m_ps[c] = int'(d[11:8]);
        if (s[0]) begin
          m_irqen[c] = d[1]; m_os[c] = d[3]; m_casc[c] = d[4];
          if (d[2] && m_lastp[c] != e - 1) m_flag[c] = 1'b0;
          if (!d[0]) m_ena[c] = 1'b0;
          else if (!m_ena[c] && m_osclr[c] != e - 1) begin
            m_ena[c] = 1'b1; m_t0[c] = e; m_cin[c] = 0;
          end
        end
      end
      2'd1: m_mod[c] = (s[1] ? int'(d[15:8]) : m_mod[c] / 256) * 256 + (s[0] ? int'(d[7:0]) : m_mod[c] % 256);
      2'd3: if (s[0]) for (int n = 0; n < NCH; n++) if (d[n] && m_lastp[n] != e - 1) m_flag[n] = 1'b0;
      default: ;
    endcase
  endtask

  task automatic xfer(input logic w, input logic [4:0] a, input logic [15:0] d, input logic [1:0] s,
                      output logic [15:0] q, output int e);
    int n;
    @(posedge clk); #1;
    cyc = 1; stb = 1; we = w; adr = a; din = d; sel = s;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack && n < 8);
    chk("ack_wait", n, 1);
    q = dout; e = cyc_n;
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d, input logic [1:0] s);
    logic [15:0] q;
    int e;
    xfer(1'b1, a, d, s, q, e);
    mdl_write(a, d, s, e);
  endtask

  task automatic rd(input logic [4:0] a, input logic [15:0] x, input string nm);
    logic [15:0] q;
    int e;
    xfer(1'b0, a, 16'h0, 2'b11, q, e);
    chk(nm, q, x);
  endtask

  // non-cascaded: pulse every MOD*2^PS clocks counted from the enabling edge; cascaded: every MOD-th input pulse
  always @(negedge clk) if (chk_on) begin
    sin = ext;
    for (int n = 0; n < NCH; n++) begin
      me = (m_mod[n] == 0) ? 64'd65536 : longint'(m_mod[n]);
      ep[n] = 1'b0;
      if (rst_n && m_ena[n]) begin
        if (m_casc[n]) begin
          if (sin) begin m_cin[n]++; ep[n] = (m_cin[n] % me) == 0; end
        end else ep[n] = ((cyc_n - m_t0[n] + 1) % (me << m_ps[n])) == 0;
      end
      sin = ep[n];
    end
    chk("pit_o", pit, ep);
    chk("cnt_flag_o", flg, m_flag);
    chk("pit_irq_o", irq, |(m_flag & m_irqen));
    if (!ack) chk("dat_idle", dout, 0);
    for (int n = 0; n < NCH; n++) if (pit[n]) begin pcnt[n]++; dut_last[n] = cyc_n; end
    if (pit[0] && pit[1]) coin++;
    if (!rst_n) mdl_reset();
    else for (int n = 0; n < NCH; n++) if (ep[n]) begin
      m_flag[n] = 1'b1; m_lastp[n] = cyc_n;
      if (m_os[n]) begin m_ena[n] = 1'b0; m_osclr[n] = cyc_n; end
    end
  end

  initial begin
    mdl_reset();
    for (int n = 0; n < NCH; n++) begin pcnt[n] = 0; dut_last[n] = 0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1; chk_on = 1;
    for (int c = 0; c < NCH; c++) for (int r = 0; r < 4; r++) rd(5'(c * 4 + r), r == 2 ? 16'd1 : 16'd0, "reset_read");
    rd(5'd20, 16'h0, "ch5_cntrl");
    rd(5'd22, 16'h0, "ch5_count");
    wr(5'd4, 16'hFFFE, 2'b11);
    rd(5'd4, 16'h0F1A, "cntrl_mask");
    wr(5'd5, 16'hFFFF, 2'b01);
    rd(5'd5, 16'h00FF, "mod_sel_lo");
    wr(5'd6, 16'hFFFE, 2'b11);
    rd(5'd6, 16'h0001, "count_ro");
    wr(5'd20, 16'hFFFF, 2'b11);
    rd(5'd20, 16'h0, "ch5_write_ignored");
    wr(5'd4, 16'h0000, 2'b11);
    wr(5'd1, 16'd4, 2'b11);
    wr(5'd0, 16'h0003, 2'b11);
    p0 = pcnt[0];
    repeat (16) @(posedge clk);
    #1 chk("periodic_pulses", pcnt[0] - p0, 4);
    chk("irq_set", irq, 1);
    chk("flag0_set", flg[0], 1);
    rd(5'd3, 16'h0001, "gstat_flag0");
    wr(5'd0, 16'h0002, 2'b11);
    wr(5'd3, 16'h0001, 2'b01);
    chk("gstat_clear_flags", flg, 0);
    chk("gstat_clear_irq", irq, 0);
    wr(5'd9, 16'd3, 2'b11);
    wr(5'd8, 16'h0209, 2'b11);
    t0 = cyc_n; p0 = pcnt[2];
    repeat (20) @(posedge clk);
    #1 chk("oneshot_count", pcnt[2] - p0, 1);
    chk("oneshot_delay", dut_last[2] - t0, 11);
    rd(5'd8, 16'h020C, "oneshot_cntrl");
    rd(5'd10, 16'h0001, "oneshot_count_reg");
    wr(5'd5, 16'd3, 2'b11);
    wr(5'd4, 16'h0011, 2'b11);
    wr(5'd0, 16'h0001, 2'b11);
    e0 = cyc_n; p0 = pcnt[0]; p1 = pcnt[1]; c0 = coin;
    repeat (36) @(posedge clk);
    #1 chk("cascade_ch0", pcnt[0] - p0, 9);
    chk("cascade_ch1", pcnt[1] - p1, 3);
    chk("cascade_coincident", coin - c0, 3);
    while ((cyc_n - e0 + 2) % 4 != 0) begin @(posedge clk); #1; end
    wr(5'd3, 16'h0001, 2'b01);
    chk("flag_collision", flg[0], 1);
    while ((cyc_n - e0 + 1) % 4 != 0) begin @(posedge clk); #1; end
    rst_n = 0; p0 = pcnt[0];
    @(posedge clk);
    #1 rst_n = 1;
    chk("reset_no_pulse", pcnt[0] - p0, 0);
    for (int c = 0; c < NCH; c++) for (int r = 0; r < 4; r++) rd(5'(c * 4 + r), r == 2 ? 16'd1 : 16'd0, "midrun_reset_read");
    wr(5'd1, 16'd2, 2'b11);
    wr(5'd0, 16'h0011, 2'b11);
    p0 = pcnt[0];
    repeat (4) begin
      @(posedge clk); #1 ext = 1;
      @(posedge clk); #1 ext = 0;
    end
    @(posedge clk);
    #1 chk("ext_sync_pulses", pcnt[0] - p0, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
